// File: rtl/minute_clock_receiver_pkg.sv
// Purpose: shared types and constants for the minute-chain receiver blocks.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package minute_clock_receiver_pkg;

  // Period-tracking state
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    STALLED = 2'd3
  } state_t;

  localparam int MINUTES_PER_HOUR = 60;
  localparam int HOURS_PER_DIAL   = 12;

  localparam int SEC_W = 8;
  localparam int MIN_W = 6;
  localparam int HR_W  = 4;

  localparam logic [SEC_W-1:0] SEC_MAX = '1;

  // Adds one optional second tick to a count, holding at the top value.
  function automatic logic [SEC_W-1:0] sat_add_sec(input logic [SEC_W-1:0] a,
                                                   input logic             b);
    if (a == SEC_MAX) return SEC_MAX;
    return a + {{(SEC_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/minute_clock_receiver_edge_synchronizer.sv
// Purpose: brings a slow asynchronous level into the clk domain and flags its rising edges.
// Latency: o_rise is high in the cycle after the second flop captures the new high level.
// Backpressure: none; the input is sampled every cycle.
// Ports: clk/rst_n (async active-low), i_async (asynchronous level),
//        o_rise (combinational one-cycle rising-edge pulse).
module edge_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_edge;

endmodule

// File: rtl/minute_clock_receiver.sv
// Purpose: receives the divider's minute clock, ticks the hands and checks each minute's length.
// Latency: minuteTick and hand updates land 3 clock edges after minuteClock is first sampled high.
// Backpressure: none; every input is sampled every cycle.
// Ports: clock/resetN (async active-low); secondTick (1-cycle pulse); minuteClock (async level);
//        setEnable/setMinute/setHour (hand load); clearError; outputs minuteTick, minuteCount,
//        hourCount, lastPeriod (saturating), locked, stalled, periodError (sticky).
module minute_clock_receiver
  import minute_clock_receiver_pkg::*;
#(
  parameter int EXPECTED_SECONDS = 60,
  parameter int TOLERANCE        = 1,
  parameter int LOCK_COUNT       = 2,
  parameter int STALL_SECONDS    = 90
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             secondTick,
  input  logic             minuteClock,
  input  logic             setEnable,
  input  logic [MIN_W-1:0] setMinute,
  input  logic [HR_W-1:0]  setHour,
  input  logic             clearError,
  output logic             minuteTick,
  output logic [MIN_W-1:0] minuteCount,
  output logic [HR_W-1:0]  hourCount,
  output logic [SEC_W-1:0] lastPeriod,
  output logic             locked,
  output logic             stalled,
  output logic             periodError
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GC_W-1:0]  GOOD_TARGET = GC_W'(LOCK_COUNT);
  localparam logic [SEC_W-1:0] GOOD_LO     = SEC_W'(EXPECTED_SECONDS - TOLERANCE);
  localparam logic [SEC_W-1:0] GOOD_HI     = SEC_W'(EXPECTED_SECONDS + TOLERANCE);
  localparam logic [SEC_W-1:0] STALL_LIM   = SEC_W'(STALL_SECONDS);
  localparam logic [MIN_W-1:0] MIN_MAX     = MIN_W'(MINUTES_PER_HOUR - 1);
  localparam logic [HR_W-1:0]  HR_MAX      = HR_W'(HOURS_PER_DIAL - 1);

  logic             w_edge;
  logic [SEC_W-1:0] w_closed;
  logic             w_good;
  logic             w_stall_hit;
  logic [GC_W-1:0]  w_good_inc;
  logic [GC_W-1:0]  w_good_nxt;
  logic             w_err_set;
  logic [MIN_W-1:0] w_set_min;
  logic [HR_W-1:0]  w_set_hr;
  state_t           w_state_nxt;

  state_t           r_state;
  logic [GC_W-1:0]  r_good_count;
  logic [SEC_W-1:0] r_sec_count;
  logic [SEC_W-1:0] r_last_period;
  logic             r_minute_tick;
  logic [MIN_W-1:0] r_minute;
  logic [HR_W-1:0]  r_hour;
  logic             r_period_error;

  edge_synchronizer u_sync (
    .clk     (clock),
    .rst_n   (resetN),
    .i_async (minuteClock),
    .o_rise  (w_edge)
  );

  // A second tick arriving in the edge cycle still belongs to the closing period.
  assign w_closed    = sat_add_sec(r_sec_count, secondTick);
  assign w_good      = (w_closed >= GOOD_LO) && (w_closed <= GOOD_HI);
  assign w_stall_hit = (r_sec_count >= STALL_LIM);
  assign w_good_inc  = r_good_count + GC_W'(1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ACQUIRE;
      r_good_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_good_count <= w_good_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  // An edge always takes precedence over a stall timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACQUIRE: if (w_edge) w_state_nxt = MEASURE;
      MEASURE: begin
        if (w_edge) begin
          if (w_good && (w_good_inc >= GOOD_TARGET)) w_state_nxt = LOCKED;
        end else if (w_stall_hit) begin
          w_state_nxt = STALLED;
        end
      end
      LOCKED: begin
        if (w_edge) begin
          if (!w_good) w_state_nxt = MEASURE;
        end else if (w_stall_hit) begin
          w_state_nxt = STALLED;
        end
      end
      STALLED: if (w_edge) w_state_nxt = MEASURE;
      default: w_state_nxt = ACQUIRE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Periods closing in ACQUIRE or STALLED are never judged.
  always_comb begin
    w_good_nxt = r_good_count;
    w_err_set  = 1'b0;
    locked     = (r_state == LOCKED);
    stalled    = (r_state == STALLED);
    if (w_edge && (r_state == MEASURE)) begin
      w_good_nxt = w_good ? w_good_inc : '0;
      w_err_set  = !w_good;
    end else if (w_edge && (r_state == LOCKED)) begin
      if (!w_good) begin
        w_good_nxt = '0;
        w_err_set  = 1'b1;
      end
    end else if (w_state_nxt == STALLED) begin
      w_good_nxt = '0;
    end
  end

  // ---------------- Period measurement ----------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_sec_count   <= '0;
      r_last_period <= '0;
      r_minute_tick <= 1'b0;
    end else begin
      r_minute_tick <= w_edge;
      if (w_edge) begin
        r_last_period <= w_closed;
        r_sec_count   <= '0;
      end else begin
        r_sec_count   <= w_closed;
      end
    end
  end

  // ---------------- Hand positions ----------------
  assign w_set_min = (setMinute > MIN_MAX) ? MIN_MAX : setMinute;
  assign w_set_hr  = (setHour > HR_MAX) ? HR_MAX : setHour;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_minute <= '0;
      r_hour   <= '0;
    end else if (setEnable) begin
      r_minute <= w_set_min;
      r_hour   <= w_set_hr;
    end else if (w_edge) begin
      if (r_minute == MIN_MAX) begin
        r_minute <= '0;
        r_hour   <= (r_hour == HR_MAX) ? '0 : r_hour + HR_W'(1);
      end else begin
        r_minute <= r_minute + MIN_W'(1);
      end
    end
  end

  // ---------------- Sticky error ----------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_period_error <= 1'b0;
    end else if (w_err_set) begin
      r_period_error <= 1'b1;
    end else if (clearError) begin
      r_period_error <= 1'b0;
    end
  end

  assign minuteTick  = r_minute_tick;
  assign minuteCount = r_minute;
  assign hourCount   = r_hour;
  assign lastPeriod  = r_last_period;
  assign periodError = r_period_error;

endmodule

// File: doc/minute_clock_receiver.md
Name: minute_clock_receiver

Overview:
Receiving end of the clock-buffer minute chain. It takes the slow toggling minute clock produced by the minute divider as an asynchronous level. It resynchronises that level into the system clock domain and turns each rising edge into a one-cycle minute tick. It keeps the analog hand positions (minute 0..59, hour 0..11) and checks each minute period, measured in second ticks, against the expected length, reporting lock, stall and error status.

Parameters:
EXPECTED_SECONDS, 60, nominal second ticks between minuteClock rising edges
TOLERANCE, 1, allowed +/- deviation for a period to count as good
LOCK_COUNT, 2, consecutive good periods needed to declare lock
STALL_SECONDS, 90, second ticks without an edge before a stall is declared; must be > EXPECTED_SECONDS+TOLERANCE and <= 255

Ports:
clock  input  1  system clock; all state updates on its rising edge
resetN  input  1  asynchronous, active-low reset
secondTick  input  1  one-cycle pulse per second, synchronous to clock
minuteClock  input  1  toggling minute clock from the divider, asynchronous to clock
setEnable  input  1  synchronous load of hand positions
setMinute  input  6  value loaded into minuteCount (0..59)
setHour  input  4  value loaded into hourCount (0..11)
clearError  input  1  clears periodError
minuteTick  output  1  one-cycle pulse per detected minuteClock rising edge
minuteCount  output  6  minute hand position 0..59
hourCount  output  4  hour hand position 0..11
lastPeriod  output  8  second ticks in the most recently closed period, saturating at 255
locked  output  1  period tracking locked
stalled  output  1  no edge within STALL_SECONDS
periodError  output  1  sticky: an out-of-tolerance period occurred

Behaviour:
- Reset (resetN low, asynchronous):
  - all outputs 0; synchroniser flops 0; secCount 0; goodCount 0; state ACQUIRE.
- Synchroniser and edge detection:
  - 2-flop synchroniser on minuteClock, then an edge register.
  - edge = sync2 & ~edgeReg.
  - minuteTick is registered from edge: high for exactly one cycle, 3 clock edges after the first edge that samples minuteClock high.
- secCount (8 bits):
  - increments on secondTick and saturates at 255.
  - In the edge cycle the period closes:
    - lastPeriod <= secCount + secondTick, saturating.
    - secCount <= 0.
  - A secondTick coincident with the edge counts toward the closing period.
- Hand positions:
  - setEnable has priority over everything: minuteCount <= setMinute and hourCount <= setHour. Out-of-range load values are clamped to 59 and 11.
  - Otherwise, each edge advances minuteCount in every state.
  - minuteCount wraps 59 -> 0, and in that same cycle hourCount increments; hourCount wraps 11 -> 0.
- Period check: good = |closed period - EXPECTED_SECONDS| <= TOLERANCE.
- State machine:
  - ACQUIRE:
    - on the first edge -> MEASURE; that period is not evaluated.
    - no stall timeout in this state.
  - MEASURE:
    - good edge: goodCount++; if goodCount reaches LOCK_COUNT -> LOCKED, locked <= 1.
    - bad edge: goodCount <= 0, periodError <= 1.
    - secCount reaches STALL_SECONDS -> STALLED.
  - LOCKED:
    - good edge: stay.
    - bad edge -> MEASURE: locked <= 0, goodCount <= 0, periodError <= 1.
    - secCount reaches STALL_SECONDS -> STALLED.
  - STALLED:
    - on entry: stalled <= 1, locked <= 0, goodCount <= 0.
    - next edge -> MEASURE, stalled <= 0; that period is not evaluated.
- periodError:
  - cleared by clearError.
  - If an error sets in the same cycle as clearError, the set wins.
- Reset asserted mid-period: everything returns to reset values; the next edge is treated as a first edge in ACQUIRE.

Decomposition:
- Shared clock-buffer package holds:
  - state enum {ACQUIRE, MEASURE, LOCKED, STALLED};
  - MINUTES_PER_HOUR = 60 and HOURS_PER_DIAL = 12;
  - width constants for seconds, minutes and hours.
- One sub-module: edge_synchronizer (2-flop sync plus rising-edge pulse, async active-low reset). It is reusable for other slow clocks in the chain.

Test Plan:
- Reset: hold resetN low with minuteClock toggling -> all outputs 0. Release, then raise minuteClock -> minuteTick high for one cycle, 3 edges later; minuteCount=1.
- Nominal: edges every 60 secondTicks -> after 1st edge MEASURE; lastPeriod=60 on the 2nd and 3rd edges; locked=1 after the 3rd edge; periodError=0.
- Wrap: setEnable with setMinute=59, setHour=11, then one edge -> minuteCount=0 and hourCount=0 in the same cycle. Separately, setEnable asserted in the same cycle as an edge -> the loaded value wins.
- Bad period while locked: period of 58 -> lastPeriod=58, locked=0, periodError=1. clearError -> 0. Next two 61-tick periods -> relock.
- Stall: locked, then no edge for 90 secondTicks -> stalled=1, locked=0. Edge at 120 -> stalled=0, MEASURE, periodError unchanged.
- Coincidence and saturation:
  - secondTick in the edge cycle -> counted, e.g. 59 ticks plus a coincident tick gives lastPeriod=60.
  - Period with more than 255 ticks (via ACQUIRE) -> lastPeriod=255.
